// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: NOP encoding, default reset PC,
// prefetch FSM state encoding and the PC increment helper.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // 32-bit modulo PC increment; 32'hFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parametric synchronous FIFO with async reset, push/pop/flush, head data
// and occupancy count. Head data is read straight from registered storage.
module fetch_fifo #(
  parameter int                DEPTH   = 4,
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;

  // Pointer and occupancy bookkeeping; flush empties without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; cleared on reset so the head reads as a NOP pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch stage: issues sequential word fetches over a req/ack
// handshake, buffers {PC+4, instr} pairs, and restarts at redirect targets,
// draining any response that was already in flight.
module instr_prefetch_unit
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc_4,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  fetch_state_t    state, state_next;
  logic [31:0]     fetch_pc, fetch_pc_next;
  logic [31:0]     addr_next;
  logic [CW-1:0]   count, count_next;
  logic            push, pop, room;
  logic [63:0]     head_data;

  // A redirect overrides both pop and push; a flushed FIFO always has room.
  assign push       = (state == ST_REQ) && imem_ack && !redirect_valid;
  assign pop        = out_valid && out_ready && !redirect_valid;
  assign count_next = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
  assign room       = count_next < DEPTH_C;

  assign imem_req  = (state != ST_IDLE);
  assign out_valid = (count != '0);
  assign out_pc_4  = head_data[63:32];
  assign out_instr = head_data[31:0];

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .DATA_W  (64),
    .RST_VAL ({32'h0, NOP_INSTR})
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data ({pc_plus4(imem_addr), imem_rdata}),
    .head_data (head_data),
    .count     (count)
  );

  // FSM state, next fetch PC and the held request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      imem_addr <= addr_next;
    end
  end

  // Next-state logic: a request in flight cannot be withdrawn, so a redirect
  // without ack parks in DRAIN until the stale response arrives.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = imem_addr;
    case (state)
      ST_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          addr_next     = redirect_pc;
          state_next    = ST_REQ;
        end else if (room) begin
          addr_next  = fetch_pc;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_valid && imem_ack) begin
          fetch_pc_next = redirect_pc;
          addr_next     = redirect_pc;
        end else if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          state_next    = ST_DRAIN;
        end else if (imem_ack) begin
          fetch_pc_next = pc_plus4(imem_addr);
          if (room) addr_next = pc_plus4(imem_addr);
          else      state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) fetch_pc_next = redirect_pc;
        if (imem_ack) begin
          addr_next  = redirect_valid ? redirect_pc : fetch_pc;
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: directed scenarios followed by a randomized
// phase, with a memory model of configurable latency and a stream scoreboard.
module tb_instr_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc_4;
  logic [31:0] out_instr;
  logic        out_ready;

  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  int          acks = 0;
  int          pops = 0;
  logic [31:0] exp_pc;
  logic        popped;
  logic [31:0] popped_pc4;
  logic        pre_ack;

  always #5 clk = ~clk;

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc_4       (out_pc_4),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  // Instruction memory contents as a function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, step, then score the program stream.
  task automatic cycle();
    logic        pv, preq;
    logic [31:0] pp4, pinstr, paddr;
    imem_ack   = imem_req && (wait_cnt >= lat);
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    pv = out_valid; pp4 = out_pc_4; pinstr = out_instr;
    preq = imem_req; paddr = imem_addr; pre_ack = imem_ack;
    @(posedge clk);
    #1;
    popped     = pv && out_ready && !redirect_valid;
    popped_pc4 = pp4;
    if (imem_ack) acks++;
    if (preq) wait_cnt = imem_ack ? 0 : wait_cnt + 1;
    else      wait_cnt = 0;
    if (popped) begin
      pops++;
      chk("pop_pc4", pp4, exp_pc + 32'd4);
      chk("pop_instr", pinstr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_pc = redirect_pc;
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
    end
    if (preq && !imem_ack) begin
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, paddr);
    end
    if (out_valid) chk("head_pair", out_instr, mem_word(out_pc_4 - 32'd4));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_cnt = 0;
    exp_pc = 32'h0;
    acks = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic saw200;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    out_ready = 1'b0;
    exp_pc = 32'h0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc4", out_pc_4, 32'h0);
    chk("rst_instr", out_instr, 32'h0);

    // Zero-wait streaming
    rst = 1'b0; wait_cnt = 0; exp_pc = 32'h0; lat = 0; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk($sformatf("seq_addr%0d", k), imem_addr, 32'(4 * (k - 1)));
      if (k >= 2) begin
        chk($sformatf("seq_valid%0d", k), {31'b0, out_valid}, 32'd1);
        chk($sformatf("seq_pc4_%0d", k), out_pc_4, 32'(4 * (k - 1)));
      end
    end

    // Backpressure fills the FIFO, then drain in order
    do_reset(); lat = 0; out_ready = 1'b0;
    repeat (10) cycle();
    chk("full_acks", 32'(acks), 32'd4);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_head", out_pc_4, 32'd4);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    cycle();
    chk("drain_pop0", popped_pc4, 32'd4);
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'd16);
    for (int k = 1; k < 4; k++) begin
      cycle();
      chk($sformatf("drain_pop%0d", k), popped_pc4, 32'(4 * (k + 1)));
    end

    // Redirect during a slow pending fetch
    do_reset(); lat = 3; out_ready = 1'b1;
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 80) begin cycle(); n++; end
    chk("t3_reach", {31'b0, imem_req && (imem_addr == 32'h8)}, 32'd1);
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    chk("t3_addr_after_redir", imem_addr, 32'h8);
    chk("t3_req_after_redir", {31'b0, imem_req}, 32'd1);
    n = 0;
    do begin
      cycle(); n++;
      if (!pre_ack) chk("t3_addr_drain", imem_addr, 32'h8);
    end while (!pre_ack && n < 20);
    chk("t3_next_addr", imem_addr, 32'h100);
    chk("t3_next_req", {31'b0, imem_req}, 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    chk("t3_first_pc4", out_pc_4, 32'h104);

    // Redirect coincident with ack
    do_reset(); lat = 0; out_ready = 1'b1;
    repeat (4) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    cycle();
    redirect_valid = 1'b0;
    chk("t4_ack_seen", {31'b0, pre_ack}, 32'd1);
    chk("t4_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h400);
    cycle();
    chk("t4_valid2", {31'b0, out_valid}, 32'd1);
    chk("t4_pc4", out_pc_4, 32'h404);

    // Two redirects while draining: latest target wins
    do_reset(); lat = 3; out_ready = 1'b1;
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h4) && n < 40) begin cycle(); n++; end
    chk("t5_reach", {31'b0, imem_req && (imem_addr == 32'h4)}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    saw200 = 1'b0;
    n = 0;
    do begin
      cycle(); n++;
      if (imem_req && imem_addr == 32'h200) saw200 = 1'b1;
    end while (!pre_ack && n < 20);
    chk("t5_next_addr", imem_addr, 32'h300);
    chk("t5_no_200", {31'b0, saw200}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    chk("t5_first_pc4", out_pc_4, 32'h304);

    // Asynchronous reset mid-transaction, stray ack afterwards
    do_reset(); lat = 0; out_ready = 1'b0;
    repeat (3) cycle();
    chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_pre_req", {31'b0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_async_req", {31'b0, imem_req}, 32'd0);
    chk("t6_async_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    chk("t6_stray_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_restart_req", {31'b0, imem_req}, 32'd1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    imem_ack = 1'b0;
    @(negedge clk);
    wait_cnt = 0; exp_pc = 32'h0; out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    chk("t6_first_pc4", out_pc_4, 32'h4);

    // Randomized traffic against the stream scoreboard
    do_reset(); pops = 0;
    for (int i = 0; i < 800; i++) begin
      if (wait_cnt == 0) lat = $urandom_range(0, 2);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      end else begin
        redirect_valid = 1'b0;
      end
      cycle();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", {31'b0, pops > 50}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
